// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : shift_sequencer
// Purpose  : Loads parallel words into a WORD_W shift register, shifts them
//            out LSB-first as a framed serial stream and flags sampled bits
//            that disagree with a shadow copy of the word.
// Option   : SHIFT_SEQ_PARITY_EN appends an even-parity bit to each frame.
// Revision : 1.0 - initial release
// ============================================================================
module shift_sequencer #(
  parameter int WORD_W   = 4,
  parameter int IDLE_GAP = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic              sr_shift,
  output logic [WORD_W-1:0] sr_data_input,
  input  logic [WORD_W-1:0] sr_data_output,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              frame_start,
  output logic              frame_done,
  output logic              sr_err
);

  localparam int              CNT_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);
  localparam logic [3:0]      GAP_LAST = 4'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SHIFT  = 3'd2,
`ifdef SHIFT_SEQ_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_GAP    = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [3:0]          gap_q, gap_d;
  logic [WORD_W-1:0]   hold_q, hold_d;
  logic [WORD_W-1:0]   shadow_q, shadow_d;
  logic                ser_out_q, ser_out_d;
  logic                ser_valid_q, ser_valid_d;
  logic                frame_start_q, frame_start_d;
  logic                frame_done_q, frame_done_d;
  logic                err_q, err_d;
`ifdef SHIFT_SEQ_PARITY_EN
  logic                parity_q, parity_d;
`endif

  logic                ready_w;
  logic                sample_w;
  logic                last_bit_w;

  // Only the LSB of the register is observed; the rest is tied off here.
  logic                unused_sr_bits;
  assign unused_sr_bits = ^sr_data_output;

  assign sample_w   = sr_data_output[0];
  assign last_bit_w = (cnt_q == CNT_LAST);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    gap_d         = gap_q;
    hold_d        = hold_q;
    shadow_d      = shadow_q;
    ser_out_d     = 1'b0;
    ser_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    err_d         = err_q;
`ifdef SHIFT_SEQ_PARITY_EN
    parity_d      = parity_q;
`endif
    ready_w       = 1'b0;
    sr_shift      = 1'b0;
    sr_data_input = '0;

    case (state_q)
      ST_IDLE: begin
        ready_w = 1'b1;
        if (in_valid) begin
          hold_d   = in_data;
          shadow_d = in_data;
          err_d    = 1'b0;
          state_d  = ST_LOAD;
        end
      end

      ST_LOAD: begin
        sr_data_input = hold_q;
        cnt_d         = '0;
`ifdef SHIFT_SEQ_PARITY_EN
        parity_d      = 1'b0;
`endif
        state_d       = ST_SHIFT;
      end

      ST_SHIFT: begin
        sr_shift      = 1'b1;
        ser_out_d     = sample_w;
        ser_valid_d   = 1'b1;
        frame_start_d = (cnt_q == '0);
        if (sample_w != shadow_q[cnt_q]) begin
          err_d = 1'b1;
        end
`ifdef SHIFT_SEQ_PARITY_EN
        parity_d = parity_q ^ sample_w;
`endif
        if (last_bit_w) begin
          gap_d = '0;
`ifdef SHIFT_SEQ_PARITY_EN
          state_d = ST_PARITY;
`else
          frame_done_d = 1'b1;
          state_d      = (IDLE_GAP > 0) ? ST_GAP : ST_IDLE;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

`ifdef SHIFT_SEQ_PARITY_EN
      ST_PARITY: begin
        ser_out_d    = parity_q;
        ser_valid_d  = 1'b1;
        frame_done_d = 1'b1;
        gap_d        = '0;
        state_d      = (IDLE_GAP > 0) ? ST_GAP : ST_IDLE;
      end
`endif

      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      gap_q         <= '0;
      hold_q        <= '0;
      shadow_q      <= '0;
      ser_out_q     <= 1'b0;
      ser_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      err_q         <= 1'b0;
`ifdef SHIFT_SEQ_PARITY_EN
      parity_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      gap_q         <= gap_d;
      hold_q        <= hold_d;
      shadow_q      <= shadow_d;
      ser_out_q     <= ser_out_d;
      ser_valid_q   <= ser_valid_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      err_q         <= err_d;
`ifdef SHIFT_SEQ_PARITY_EN
      parity_q      <= parity_d;
`endif
    end
  end

  // The state register already sits in IDLE while reset is held, so gate it.
  assign in_ready    = ready_w & ~reset;
  assign ser_out     = ser_out_q;
  assign ser_valid   = ser_valid_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign sr_err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_sequencer
// Purpose  : Self-checking bench for shift_sequencer with a shift-register
//            plant and a frame-level timeline model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_sequencer;

  localparam int W   = 4;
  localparam int G   = 1;
  localparam int N   = 4096;
  localparam int BIG = 1 << 30;
`ifdef SHIFT_SEQ_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         sr_shift;
  logic [W-1:0] sr_data_input;
  logic [W-1:0] sr_data_output;
  logic         ser_out;
  logic         ser_valid;
  logic         frame_start;
  logic         frame_done;
  logic         sr_err;

  logic [W-1:0] sr_q;
  logic         force_lsb0;

  int checks = 0;
  int errors = 0;
  int cyc;
  int next_free;
  int err_set;
  int fault_cycle;
  int pend_fault;
  int last_accept;
  bit accepted;

  bit           exp_sv [N];
  bit           exp_ser[N];
  bit           exp_st [N];
  bit           exp_dn [N];
  bit           exp_sh [N];
  logic [W-1:0] exp_di [N];

  always #5 clk = ~clk;

  shift_sequencer #(.WORD_W(W), .IDLE_GAP(G)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .sr_shift       (sr_shift),
    .sr_data_input  (sr_data_input),
    .sr_data_output (sr_data_output),
    .ser_out        (ser_out),
    .ser_valid      (ser_valid),
    .frame_start    (frame_start),
    .frame_done     (frame_done),
    .sr_err         (sr_err)
  );

  // Plant: load on !shift, logical right shift on shift.
  always @(posedge clk or posedge reset) begin
    if (reset)         sr_q <= '0;
    else if (sr_shift) sr_q <= {1'b0, sr_q[W-1:1]};
    else               sr_q <= sr_data_input;
  end
  assign sr_data_output = force_lsb0 ? {sr_q[W-1:1], 1'b0} : sr_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic clear_from(input int c);
    for (int i = c; i < N; i++) begin
      exp_sv[i] = 0; exp_ser[i] = 0; exp_st[i] = 0;
      exp_dn[i] = 0; exp_sh[i] = 0; exp_di[i] = '0;
    end
  endtask

  // Frame timeline from the handshake cycle t.
  task automatic accept(input int t, input logic [W-1:0] w, input int fb);
    bit b;
    bit par;
    par = 0;
    exp_di[t+1] = w;
    for (int i = 0; i < W; i++) begin
      b = (i == fb) ? 1'b0 : w[i];
      par ^= b;
      exp_sh[t+2+i]  = 1;
      exp_sv[t+3+i]  = 1;
      exp_ser[t+3+i] = b;
    end
    exp_st[t+3] = 1;
    if (PAR != 0) begin
      exp_sv[t+3+W]  = 1;
      exp_ser[t+3+W] = par;
    end
    exp_dn[t+2+W+PAR] = 1;
    err_set     = (fb >= 0 && w[fb] == 1'b1) ? t + 3 + fb : BIG;
    fault_cycle = (fb >= 0) ? t + 2 + fb : -1;
    next_free   = t + 2 + W + G + PAR;
    last_accept = t;
    accepted    = 1;
  endtask

  task automatic run_cycle();
    @(negedge clk);
    chk("in_ready", 32'(in_ready), 32'((!reset && cyc >= next_free) ? 1 : 0));
    chk("sr_shift", 32'(sr_shift), 32'(exp_sh[cyc]));
    chk("sr_data_input", 32'(sr_data_input), 32'(exp_di[cyc]));
    chk("ser_valid", 32'(ser_valid), 32'(exp_sv[cyc]));
    if (exp_sv[cyc]) chk("ser_out", 32'(ser_out), 32'(exp_ser[cyc]));
    chk("frame_start", 32'(frame_start), 32'(exp_st[cyc]));
    chk("frame_done", 32'(frame_done), 32'(exp_dn[cyc]));
    chk("sr_err", 32'(sr_err), 32'((cyc >= err_set) ? 1 : 0));
    if (!reset && cyc >= next_free && in_valid) begin
      accept(cyc, in_data, pend_fault);
      pend_fault = -1;
    end
    @(posedge clk);
    #1;
    cyc++;
    force_lsb0 = (cyc == fault_cycle);
  endtask

  task automatic do_reset(input int n);
    reset       = 1;
    in_valid    = 0;
    fault_cycle = -1;
    force_lsb0  = 0;
    err_set     = BIG;
    clear_from(cyc);
    repeat (n) run_cycle();
    reset     = 0;
    next_free = cyc;
  endtask

  task automatic offer(input logic [W-1:0] w, input int fb, input bit keep);
    in_valid   = 1;
    in_data    = w;
    pend_fault = fb;
    accepted   = 0;
    for (int k = 0; k < 40 && !accepted; k++) run_cycle();
    if (!keep) in_valid = 0;
    pend_fault = -1;
  endtask

  initial begin
    reset = 1; in_valid = 0; in_data = '0; force_lsb0 = 0;
    cyc = 0; next_free = 0; err_set = BIG; fault_cycle = -1;
    pend_fault = -1; last_accept = 0; accepted = 0;
    clear_from(0);
    @(posedge clk);
    #1;
    do_reset(3);
    repeat (2) run_cycle();

    // Basic frame, then the parity-test word.
    offer(4'b1011, -1, 0);
    repeat (8) run_cycle();
    offer(4'b0111, -1, 0);
    repeat (9) run_cycle();

    // Back-to-back with in_valid held high.
    offer(4'hA, -1, 1);
    offer(4'h5, -1, 0);
    repeat (9) run_cycle();

    // Forced LSB fault on bit 2, then a clean word clears sr_err.
    offer(4'hF, 2, 0);
    repeat (10) run_cycle();
    offer(4'(W'($urandom)), -1, 0);
    repeat (9) run_cycle();

    // Reset during SHIFT bit 1.
    offer(4'hC, -1, 0);
    while (cyc < last_accept + 3) run_cycle();
    do_reset(2);
    repeat (3) run_cycle();

    // Randomised traffic: toggling in_valid, random words and faults.
    for (int k = 0; k < 250; k++) begin
      in_valid   = 1'($urandom_range(0, 1));
      in_data    = 4'(W'($urandom));
      pend_fault = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W - 1)) : -1;
      run_cycle();
    end
    in_valid = 0;
    pend_fault = -1;
    repeat (12) run_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shift_sequencer.md
# shift_sequencer

Upstream controller for the 4-bit shift-register stage. It accepts parallel words over a valid/ready handshake and drives the register's `shift` and `data_input` pins to load then shift each word. It samples the register's LSB each shift cycle to emit an LSB-first serial stream with frame strobes. It also checks the sampled bits against a shadow copy and flags any mismatch.

## Interface
- `WORD_W`, 4: word width; must equal the shift-register width.
- `IDLE_GAP`, 1: idle cycles inserted after each frame, range 0..15.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `in_valid`  in  1  parallel word offered.
- `in_data`  in  WORD_W  word to serialise.
- `in_ready`  out  1  high only in IDLE.
- `sr_shift`  out  1  to shift register `shift`.
- `sr_data_input`  out  WORD_W  to shift register `data_input`.
- `sr_data_output`  in  WORD_W  from shift register `data_output`.
- `ser_out`  out  1  serial bit, registered.
- `ser_valid`  out  1  `ser_out` carries a frame bit this cycle.
- `frame_start`  out  1  one-cycle pulse with bit 0.
- `frame_done`  out  1  one-cycle pulse with the last bit of the frame.
- `sr_err`  out  1  sticky; a sampled LSB mismatched the shadow bit.

## Operation
- States: IDLE, LOAD, SHIFT, PARITY (only when the macro is defined), GAP.
- IDLE:
  - `in_ready`=1, `sr_shift`=0, `sr_data_input`=0, so the register holds zeros.
  - On `in_valid & in_ready`, capture `in_data` into the hold and shadow registers, clear `sr_err`, and go to LOAD.
- LOAD (1 cycle): `sr_shift`=0, `sr_data_input`=hold. The register loads the word at the end of this cycle. Next state is SHIFT.
- SHIFT (WORD_W cycles, bit counter 0..WORD_W-1):
  - Drive `sr_shift`=1 and `sr_data_input`=0.
  - Each cycle, sample `sr_data_output[0]` into the output register.
  - Compare the sample with `shadow[cnt]`; on mismatch set `sr_err`.
  - XOR the sample into the parity accumulator.
  - After the last bit, go to PARITY if the macro is defined, else to GAP, or to IDLE when `IDLE_GAP`=0.
- PARITY (1 cycle): load the output register with the even-parity bit, which is the XOR of the sampled bits. `sr_shift`=0, `sr_data_input`=0.
- GAP: count `IDLE_GAP` cycles with `sr_shift`=0 and `sr_data_input`=0, then go to IDLE.
- `in_valid` outside IDLE is ignored; the word is not consumed.
- The bit counter is WORD_W-wide-safe; `$clog2(WORD_W)` bits with no wrap inside a frame.
- Reset mid-frame:
  - All outputs go to 0 and the state goes to IDLE.
  - The frame is dropped with no `frame_done`.
  - The shift register is cleared by its own reset.

## Timing
- Reset values: `in_ready`=0 while reset is asserted, 1 in the first cycle after release. All other outputs are 0.
- Handshake at edge t (`in_valid & in_ready` high in cycle t):
  - cycle t+1 is LOAD;
  - bit 0 is on `ser_out` in cycle t+3;
  - bit i appears in cycle t+3+i.
- `ser_valid` is high for the data bits, plus the parity bit in cycle t+3+WORD_W when enabled.
- `frame_start` fires in cycle t+3.
- `frame_done` fires in the cycle of the last valid bit:
  - t+2+WORD_W without parity;
  - t+3+WORD_W with parity.
- The next `in_ready` rises once GAP completes. Minimum handshake-to-handshake spacing is 2+WORD_W+IDLE_GAP cycles, plus 1 with parity.
- `sr_err` updates one cycle after the faulty sample, and holds until the next accepted word or reset.

## Configuration
- `SHIFT_SEQ_PARITY_EN` defined:
  - The PARITY state exists.
  - Each frame is WORD_W+1 serial bits, ending with the even-parity bit.
  - `frame_done` aligns with the parity bit.
- `SHIFT_SEQ_PARITY_EN` undefined:
  - There is no PARITY state and no accumulator logic.
  - Each frame is WORD_W bits.
  - `frame_done` aligns with bit WORD_W-1.

## Test plan
- Reset, then `in_valid`=1 with `in_data`=4'b1011 at edge t (parity off) -> `ser_out` reads 1,1,0,1 in cycles t+3..t+6; `frame_start` at t+3; `frame_done` at t+6; `sr_err`=0.
- Parity on, `in_data`=4'b0111 -> bits 1,1,1,0 then parity 1 at t+7; `frame_done` at t+7.
- Back-to-back words 4'hA then 4'h5 with `in_valid` held high, `IDLE_GAP`=1 -> the second handshake occurs 7 cycles after the first (parity off), and the streams do not overlap.
- Force `sr_data_output[0]`=0 during bit 2 of word 4'hF -> `sr_err` rises, stays set through the frame, and clears on the next handshake.
- Assert `reset` during SHIFT bit 1 -> all outputs are 0 immediately, `frame_done` never pulses, and `in_ready`=1 one cycle after release.
- `in_valid` toggling during SHIFT/GAP -> no capture; `in_ready` stays 0 and the word currently being serialised is unaffected.
